imm_packer: RTL and testbench
=============================

Name: imm_packer

Overview:
Encoder counterpart to the core's immediate extender: takes a 32-bit signed immediate plus an immediate-format select and scatters it into the immediate bit positions of a RISC-V instruction word. Non-immediate fields come from a base instruction. It is a 2-stage elastic valid/ready pipeline that range-checks and alignment-checks each immediate and keeps a saturating error count. It sits in the boot/debug instruction-injection path, in front of instruction memory writes.

Parameters:
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream request valid.
in_ready  output  1  block can accept a request this cycle.
base_instr  input  32  instruction supplying opcode, rd, rs1, rs2 and funct bits; its immediate bit positions are ignored.
imm  input  32  signed immediate value (byte offset for B/J).
imm_src  input  2  format: 00 I, 01 S, 10 B, 11 J (same encoding as the extender).
out_valid  output  1  packed result valid.
out_ready  input  1  downstream accepts the result.
instr  output  32  packed instruction.
range_err  output  1  immediate does not fit the format (qualified by out_valid).
align_err  output  1  B/J immediate has bit 0 set (qualified by out_valid).
err_count  output  ERR_CNT_W  saturating count of results delivered with any error.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, instr=0, range_err=0, align_err=0, err_count=0. in_ready=1 one cycle after deassertion. A transaction in flight at reset is dropped, not delivered.
- Handshake: a transfer occurs when valid&&ready on a rising edge. in_ready = !s1_valid || s1_advance. s1_advance = s1_valid && (!s2_valid || out_ready). Registered outputs come from stage 2. Outputs hold stable while out_valid && !out_ready.
- Latency: 2 cycles from input acceptance to out_valid with no backpressure. Throughput is 1 per cycle. No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready only.
- Stage 1 registers base_instr, imm and imm_src, and computes the flags:
  - I/S: range_err = imm[31:11] not all-equal.
  - B: range_err = imm[31:12] not all-equal; align_err = imm[0].
  - J: range_err = imm[31:20] not all-equal; align_err = imm[0].
  - I/S never set align_err.
- Stage 2 packs the immediate; all other bits come from base_instr:
  - I: instr[31:20]=imm[11:0].
  - S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0].
  - B: instr[31]=imm[12], instr[30:25]=imm[10:5], instr[11:8]=imm[4:1], instr[7]=imm[11].
  - J: instr[31]=imm[20], instr[30:21]=imm[10:1], instr[20]=imm[11], instr[19:12]=imm[19:12].
- On error, the packed word is still produced from the truncated bits, with the flags set. The block never stalls or drops on error.
- err_count increments by 1 on each output transfer (out_valid&&out_ready) with range_err||align_err. It saturates at all-ones and does not wrap.
- Round-trip invariant: if both flags are 0, extending instr with the same imm_src returns imm exactly.
- Simultaneous accept in stage 1 and drain from stage 2 in the same cycle is legal, with no bubble.

Test Plan:
- I, base 0x00000013, imm 0xFFFFFFFF -> instr 0xFFF00013, no flags, out_valid exactly 2 cycles after accept.
- S, base 0x00002023, imm 0x000007FF -> instr 0x7E002FA3. B, base 0x00000063, imm 0xFFFFFFFC -> 0xFE000EE3. J, base 0x0000006F, imm 0x00000800 -> 0x0010006F.
- Errors: I with imm 0x00000800 -> instr 0x80000013, range_err=1. B with imm 0x00000005 -> align_err=1, range_err=0. err_count increments only on output transfer.
- Backpressure: stream of 4 back-to-back requests with out_ready held 0 for 3 cycles -> in_ready drops after 2 accepted, outputs stable, all 4 delivered in order with no loss or duplication.
- Saturation: ERR_CNT_W=2, 5 erroneous transfers -> err_count sequence 1,2,3,3,3.
- Reset mid-stream: assert rst_n=0 with both stages full -> out_valid=0 and err_count=0 immediately (async), no stale output after release; randomized round-trip against a reference extender model passes.

Source files
------------

// File: rtl/imm_packer.sv
// imm_packer: scatters a signed immediate into the I/S/B/J immediate bit positions of a
// RISC-V base instruction through a 2-stage elastic valid/ready pipeline with error flags.
module imm_packer #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          base_instr,
  input  logic [31:0]          imm,
  input  logic [1:0]           imm_src,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instr,
  output logic                 range_err,
  output logic                 align_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  logic                 s1_valid_q, s1_valid_d;
  logic [31:0]          s1_base_q, s1_base_d;
  logic [20:0]          s1_imm_q, s1_imm_d;
  logic [1:0]           s1_src_q, s1_src_d;
  logic                 s1_range_q, s1_range_d;
  logic                 s1_align_q, s1_align_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [31:0]          instr_q, instr_d;
  logic                 range_q, range_d;
  logic                 align_q, align_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic        s1_advance;
  logic        s1_load;
  logic        out_xfer;
  logic        range_in;
  logic        align_in;
  logic [31:0] pack_w;

  assign s1_advance = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready   = !s1_valid_q || s1_advance;
  assign s1_load    = in_valid && in_ready;
  assign out_xfer   = s2_valid_q && out_ready;

  // The immediate fits when every bit above the format's sign bit matches it.
  always_comb begin
    range_in = 1'b0;
    align_in = 1'b0;
    case (imm_src)
      IMM_I, IMM_S: range_in = !((&imm[31:11]) || !(|imm[31:11]));
      IMM_B: begin
        range_in = !((&imm[31:12]) || !(|imm[31:12]));
        align_in = imm[0];
      end
      default: begin
        range_in = !((&imm[31:20]) || !(|imm[31:20]));
        align_in = imm[0];
      end
    endcase
  end

  // Only imm[20:0] can ever land in the instruction word, so stage 1 keeps just those.
  always_comb begin
    pack_w = s1_base_q;
    case (s1_src_q)
      IMM_I: pack_w[31:20] = s1_imm_q[11:0];
      IMM_S: begin
        pack_w[31:25] = s1_imm_q[11:5];
        pack_w[11:7]  = s1_imm_q[4:0];
      end
      IMM_B: begin
        pack_w[31]    = s1_imm_q[12];
        pack_w[30:25] = s1_imm_q[10:5];
        pack_w[11:8]  = s1_imm_q[4:1];
        pack_w[7]     = s1_imm_q[11];
      end
      default: begin
        pack_w[31]    = s1_imm_q[20];
        pack_w[30:21] = s1_imm_q[10:1];
        pack_w[20]    = s1_imm_q[11];
        pack_w[19:12] = s1_imm_q[19:12];
      end
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_base_d   = s1_base_q;
    s1_imm_d    = s1_imm_q;
    s1_src_d    = s1_src_q;
    s1_range_d  = s1_range_q;
    s1_align_d  = s1_align_q;
    s2_valid_d  = s2_valid_q;
    instr_d     = instr_q;
    range_d     = range_q;
    align_d     = align_q;
    err_count_d = err_count_q;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_base_d  = base_instr;
      s1_imm_d   = imm[20:0];
      s1_src_d   = imm_src;
      s1_range_d = range_in;
      s1_align_d = align_in;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    if (s1_advance) begin
      s2_valid_d = 1'b1;
      instr_d    = pack_w;
      range_d    = s1_range_q;
      align_d    = s1_align_q;
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end

    if (out_xfer && (range_q || align_q) && !(&err_count_q)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_base_q   <= '0;
      s1_imm_q    <= '0;
      s1_src_q    <= '0;
      s1_range_q  <= 1'b0;
      s1_align_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      instr_q     <= '0;
      range_q     <= 1'b0;
      align_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_base_q   <= s1_base_d;
      s1_imm_q    <= s1_imm_d;
      s1_src_q    <= s1_src_d;
      s1_range_q  <= s1_range_d;
      s1_align_q  <= s1_align_d;
      s2_valid_q  <= s2_valid_d;
      instr_q     <= instr_d;
      range_q     <= range_d;
      align_q     <= align_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign instr     = instr_q;
  assign range_err = range_q;
  assign align_err = align_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_packer.sv
// Self-checking bench for imm_packer: directed vectors, backpressure, counter saturation,
// mid-stream reset and a randomized scoreboard checked through a reference immediate extender.
module tb_imm_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] base_instr;
  logic [31:0] imm;
  logic [1:0]  imm_src;
  logic        out_ready;

  logic        in_ready, out_valid, range_err, align_err;
  logic [31:0] instr;
  logic [7:0]  err_count;

  logic        in_ready2, out_valid2, range_err2, align_err2;
  logic [31:0] instr2;
  logic [1:0]  err_count2;

  int checks = 0;
  int errors = 0;
  int exp_err8 = 0;
  int exp_err2 = 0;

  typedef struct {
    logic [31:0] base;
    logic [31:0] imm;
    logic [1:0]  src;
    logic [31:0] instr;
    logic        rng;
    logic        aln;
  } vec_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] imm;
    logic [1:0]  src;
  } req_t;

  vec_t vecs [6];
  req_t sb [$];

  imm_packer #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .base_instr(base_instr), .imm(imm), .imm_src(imm_src),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .range_err(range_err), .align_err(align_err), .err_count(err_count)
  );

  imm_packer #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .base_instr(base_instr), .imm(imm), .imm_src(imm_src),
    .out_valid(out_valid2), .out_ready(out_ready), .instr(instr2),
    .range_err(range_err2), .align_err(align_err2), .err_count(err_count2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Reference extender: recovers the immediate a decoder would see in a packed word.
  function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [1:0] src);
    case (src)
      2'd0:    return {{20{w[31]}}, w[31:20]};
      2'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      2'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  function automatic int imm_bits(input logic [1:0] src);
    return (src < 2'd2) ? 12 : (src == 2'd2) ? 13 : 21;
  endfunction

  function automatic logic [31:0] ref_trunc(input logic [31:0] v, input logic [1:0] src);
    int t;
    int sh;
    sh = 32 - imm_bits(src);
    t = v;
    t = t <<< sh;
    t = t >>> sh;
    if (src >= 2'd2) t = t & ~1;
    return t;
  endfunction

  function automatic logic [31:0] imm_mask(input logic [1:0] src);
    case (src)
      2'd0:    return 32'hFFF0_0000;
      2'd3:    return 32'hFFFF_F000;
      default: return 32'hFE00_0F80;
    endcase
  endfunction

  task automatic bump_err();
    exp_err8 = (exp_err8 < 255) ? exp_err8 + 1 : 255;
    exp_err2 = (exp_err2 < 3) ? exp_err2 + 1 : 3;
  endtask

  task automatic drive_vec(input int k);
    base_instr = vecs[k].base;
    imm        = vecs[k].imm;
    imm_src    = vecs[k].src;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    base_instr = '0; imm = '0; imm_src = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || instr !== 32'h0 || range_err !== 1'b0 || align_err !== 1'b0)
      begin errors++; $display("FAIL reset_outputs got v=%b i=%h r=%b a=%b want 0", out_valid, instr, range_err, align_err); end
    checks++;
    if (err_count !== 8'd0 || err_count2 !== 2'd0)
      begin errors++; $display("FAIL reset_errcnt got %0d/%0d want 0", err_count, err_count2); end
    rst_n = 1'b1;
    exp_err8 = 0; exp_err2 = 0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    for (int k = 0; k < 6; k++) begin
      drive_vec(k);
      in_valid = 1'b1; out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_accept vec %0d got %b want 1", k, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_latency_early vec %0d got %b want 0", k, out_valid); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL dir_latency vec %0d got %b want 1", k, out_valid); end
      checks++;
      if (instr !== vecs[k].instr) begin errors++; $display("FAIL dir_instr vec %0d got %h want %h", k, instr, vecs[k].instr); end
      checks++;
      if (range_err !== vecs[k].rng || align_err !== vecs[k].aln)
        begin errors++; $display("FAIL dir_flags vec %0d got r=%b a=%b want r=%b a=%b", k, range_err, align_err, vecs[k].rng, vecs[k].aln); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || instr !== vecs[k].instr) begin errors++; $display("FAIL dir_hold vec %0d got v=%b i=%h want v=1 i=%h", k, out_valid, instr, vecs[k].instr); end
      checks++;
      if (err_count !== exp_err8[7:0]) begin errors++; $display("FAIL dir_errcnt_stall vec %0d got %0d want %0d", k, err_count, exp_err8); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      if (vecs[k].rng || vecs[k].aln) bump_err();
      checks++;
      if (out_valid !== 1'b0 || err_count !== exp_err8[7:0])
        begin errors++; $display("FAIL dir_errcnt_xfer vec %0d got v=%b cnt=%0d want v=0 cnt=%0d", k, out_valid, err_count, exp_err8); end
      out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    int recv;
    logic [31:0] prev_instr;
    logic prev_stall;
    sent = 0; recv = 0; prev_instr = '0; prev_stall = 1'b0;
    for (int cyc = 0; cyc < 20 && recv < 4; cyc++) begin
      if (sent < 4) begin drive_vec(sent); in_valid = 1'b1; end
      else in_valid = 1'b0;
      out_ready = (cyc >= 5);
      @(negedge clk);
      if (cyc == 2) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 2) begin errors++; $display("FAIL bp_in_ready got rdy=%b sent=%0d want rdy=0 sent=2", in_ready, sent); end
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || instr !== prev_instr) begin errors++; $display("FAIL bp_hold got v=%b i=%h want v=1 i=%h", out_valid, instr, prev_instr); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (instr !== vecs[recv].instr || range_err !== 1'b0 || align_err !== 1'b0)
          begin errors++; $display("FAIL bp_order item %0d got %h want %h", recv, instr, vecs[recv].instr); end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_instr = instr;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (recv != 4) begin errors++; $display("FAIL bp_count got %0d want 4", recv); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate got v=%b want 0", out_valid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    logic [1:0] seq [5];
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd3; seq[4] = 2'd3;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_err8 = 0; exp_err2 = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      drive_vec(4);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid2 !== 1'b1 || range_err2 !== 1'b1) begin errors++; $display("FAIL sat_valid step %0d got v=%b r=%b want 1/1", k, out_valid2, range_err2); end
      @(posedge clk); #1;
      bump_err();
      checks++;
      if (err_count2 !== seq[k]) begin errors++; $display("FAIL sat_count step %0d got %0d want %0d", k, err_count2, seq[k]); end
      checks++;
      if (err_count !== exp_err8[7:0]) begin errors++; $display("FAIL sat_wide_count step %0d got %0d want %0d", k, err_count, exp_err8); end
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive_vec(4); in_valid = 1'b1;
    @(posedge clk); #1;
    drive_vec(5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got v=%b rdy=%b want 1/0", out_valid, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || err_count !== 8'd0 || err_count2 !== 2'd0)
      begin errors++; $display("FAIL mid_async got v=%b cnt=%0d/%0d want 0", out_valid, err_count, err_count2); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_err8 = 0; exp_err2 = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale cycle %0d got v=%b want 0", i, out_valid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    req_t r;
    int t;
    int w;
    int v;
    int lim;
    logic exp_rng;
    logic exp_aln;
    sb.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc >= 590) begin
        in_valid = 1'b0; out_ready = 1'b1;
      end else begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        w = $urandom_range(1, 32);
        t = $urandom;
        t = t <<< (32 - w);
        t = t >>> (32 - w);
        imm = t;
        if ($urandom_range(0, 1) == 1) imm[0] = 1'b0;
        imm_src = 2'($urandom_range(0, 3));
        base_instr = $urandom;
      end
      @(negedge clk);
      checks++;
      if (err_count !== exp_err8[7:0] || err_count2 !== exp_err2[1:0])
        begin errors++; $display("FAIL rnd_errcnt cycle %0d got %0d/%0d want %0d/%0d", cyc, err_count, err_count2, exp_err8, exp_err2); end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rnd_spurious cycle %0d got unexpected output %h want none", cyc, instr);
        end else begin
          r = sb.pop_front();
          v = r.imm;
          lim = 1 <<< (imm_bits(r.src) - 1);
          exp_rng = (v < -lim) || (v >= lim);
          exp_aln = (r.src >= 2'd2) && r.imm[0];
          checks++;
          if (range_err !== exp_rng || align_err !== exp_aln)
            begin errors++; $display("FAIL rnd_flags imm %h src %0d got r=%b a=%b want r=%b a=%b", r.imm, r.src, range_err, align_err, exp_rng, exp_aln); end
          checks++;
          if (ref_ext(instr, r.src) !== ref_trunc(r.imm, r.src))
            begin errors++; $display("FAIL rnd_roundtrip imm %h src %0d got %h want %h", r.imm, r.src, ref_ext(instr, r.src), ref_trunc(r.imm, r.src)); end
          checks++;
          if ((instr & ~imm_mask(r.src)) !== (r.base & ~imm_mask(r.src)))
            begin errors++; $display("FAIL rnd_fields src %0d got %h want %h", r.src, instr & ~imm_mask(r.src), r.base & ~imm_mask(r.src)); end
          if (exp_rng || exp_aln) bump_err();
        end
      end
      if (in_valid && in_ready) begin
        r.base = base_instr; r.imm = imm; r.src = imm_src;
        sb.push_back(r);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d pending want 0", sb.size()); end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0013, 32'hFFFF_FFFF, 2'd0, 32'hFFF0_0013, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_2023, 32'h0000_07FF, 2'd1, 32'h7E00_2FA3, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0063, 32'hFFFF_FFFC, 2'd2, 32'hFE00_0EE3, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_006F, 32'h0000_0800, 2'd3, 32'h0010_006F, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0013, 32'h0000_0800, 2'd0, 32'h8000_0013, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_0063, 32'h0000_0005, 2'd2, 32'h0000_0263, 1'b0, 1'b1};

    test_reset();
    test_directed();
    test_back_to_back();
    test_saturation();
    test_reset_midstream();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
